// File: rtl/alu_wide_seq.sv
// Purpose : sequences an NBYTES-wide op over the shared 8-bit alu, one byte per cycle, LSB first.
// Latency : resp_valid rises NBYTES cycles after acceptance for group 00, and 1 cycle after for other groups.
// Backpr. : accepts one request only in IDLE, then holds the result in DONE until resp_ready.
// Ports   : clk/rst (sync, active-high); req_* valid/ready request; resp_* valid/ready wide result + flags;
//           alu_operand_a/b, alu_group, alu_op, alu_carry_in drive the alu (zero outside EXEC);
//           alu_result, alu_flag_z/n/c/v return from the alu.
module alu_wide_seq #(
  parameter int         NBYTES = 2,
  parameter logic [5:0] OP_ADD = 6'd0,
  parameter logic [5:0] OP_ADC = 6'd1,
  parameter logic [5:0] OP_SUB = 6'd2,
  parameter logic [5:0] OP_SBC = 6'd3,
  localparam int        W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [1:0]   req_group,
  input  logic [5:0]   req_op,
  input  logic         req_carry_in,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_result,
  output logic         resp_z,
  output logic         resp_n,
  output logic         resp_c,
  output logic         resp_v,
  output logic [7:0]   alu_operand_a,
  output logic [7:0]   alu_operand_b,
  output logic [1:0]   alu_group,
  output logic [5:0]   alu_op,
  output logic         alu_carry_in,
  input  logic [7:0]   alu_result,
  input  logic         alu_flag_z,
  input  logic         alu_flag_n,
  input  logic         alu_flag_c,
  input  logic         alu_flag_v
);

  localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state;
  logic [IW-1:0]           byte_idx;
  logic [NBYTES-1:0][7:0]  a_lat;
  logic [NBYTES-1:0][7:0]  b_lat;
  logic [NBYTES-1:0][7:0]  res_q;
  logic [1:0]              group_q;
  logic [5:0]              op_q;
  logic                    cin_q;
  logic                    carry_q;
  logic                    z_acc;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    resp_z_q;
  logic                    resp_c_q;
  logic                    resp_v_q;

  // Per-byte negative flag is irrelevant: wide N comes straight from the top result bit.
  logic unused_alu_flag_n;
  assign unused_alu_flag_n = alu_flag_n;

  logic is_narrow;
  logic last_byte;
  logic upper_a_zero;
  logic z_final;

  assign is_narrow    = (group_q != 2'b00);
  assign last_byte    = is_narrow || (byte_idx == LAST_IDX);
  assign upper_a_zero = (a_lat[NBYTES-1:1] == '0);
  // Narrow ops pass the upper A bytes through, so they take part in wide Z.
  assign z_final      = is_narrow ? (alu_flag_z && upper_a_zero) : (z_acc && alu_flag_z);

  // The alu is only ours while in EXEC; park its inputs at zero otherwise.
  always_comb begin
    alu_operand_a = '0;
    alu_operand_b = '0;
    alu_group     = '0;
    alu_op        = '0;
    alu_carry_in  = 1'b0;
    if (state == EXEC) begin
      alu_operand_a = a_lat[byte_idx];
      alu_operand_b = b_lat[byte_idx];
      alu_group     = group_q;
      alu_op        = op_q;
      alu_carry_in  = cin_q;
      if (byte_idx != '0) begin
        alu_carry_in = carry_q;
        if (op_q == OP_ADD) alu_op = OP_ADC;
        else if (op_q == OP_SUB) alu_op = OP_SBC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_idx     <= '0;
      a_lat        <= '0;
      b_lat        <= '0;
      res_q        <= '0;
      group_q      <= '0;
      op_q         <= '0;
      cin_q        <= 1'b0;
      carry_q      <= 1'b0;
      z_acc        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_z_q     <= 1'b0;
      resp_c_q     <= 1'b0;
      resp_v_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_lat       <= req_a;
            b_lat       <= req_b;
            group_q     <= req_group;
            op_q        <= req_op;
            cin_q       <= req_carry_in;
            // Preload with A so narrow ops leave bytes 1.. equal to A.
            res_q       <= req_a;
            byte_idx    <= '0;
            z_acc       <= 1'b1;
            req_ready_q <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          res_q[byte_idx] <= alu_result;
          z_acc           <= z_acc && alu_flag_z;
          carry_q         <= alu_flag_c;
          if (last_byte) begin
            resp_z_q     <= z_final;
            resp_c_q     <= alu_flag_c;
            resp_v_q     <= alu_flag_v;
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end else begin
            byte_idx <= byte_idx + IW'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = res_q;
  assign resp_n      = res_q[NBYTES-1][7];
  assign resp_z      = resp_z_q;
  assign resp_c      = resp_c_q;
  assign resp_v      = resp_v_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
module tb_alu_wide_seq;
  localparam int W = 16;
  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_ADC = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_SBC = 6'd3;
  localparam logic [5:0] OP_AND = 6'd4;
  localparam logic [5:0] OP_OR  = 6'd5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [1:0]   req_group = '0;
  logic [5:0]   req_op = '0;
  logic         req_carry_in = 1'b0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_result;
  logic         resp_z, resp_n, resp_c, resp_v;
  logic [7:0]   alu_operand_a, alu_operand_b, alu_result;
  logic [1:0]   alu_group;
  logic [5:0]   alu_op;
  logic         alu_carry_in, alu_flag_z, alu_flag_n, alu_flag_c, alu_flag_v;

  always #5 clk = ~clk;

  alu_wide_seq #(.NBYTES(2), .OP_ADD(OP_ADD), .OP_ADC(OP_ADC), .OP_SUB(OP_SUB), .OP_SBC(OP_SBC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_group(req_group), .req_op(req_op), .req_carry_in(req_carry_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_z(resp_z), .resp_n(resp_n), .resp_c(resp_c), .resp_v(resp_v),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_group(alu_group),
    .alu_op(alu_op), .alu_carry_in(alu_carry_in), .alu_result(alu_result),
    .alu_flag_z(alu_flag_z), .alu_flag_n(alu_flag_n), .alu_flag_c(alu_flag_c), .alu_flag_v(alu_flag_v)
  );

  // 8-bit alu stand-in. C is carry-out for add and borrow-out for sub.
  typedef struct packed { logic [7:0] r; logic c; logic v; } a8_t;

  function automatic a8_t alu8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] g,
                               input logic [5:0] op, input logic cin);
    logic [8:0] s;
    a8_t o;
    o = '0;
    s = '0;
    if (g == 2'b00) begin
      if (op == OP_ADD || op == OP_ADC) begin
        s = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? {8'd0, cin} : 9'd0);
        o.r = s[7:0]; o.c = s[8]; o.v = (a[7] == b[7]) && (o.r[7] != a[7]);
      end else if (op == OP_SUB || op == OP_SBC) begin
        s = {1'b0, a} - {1'b0, b} - ((op == OP_SBC) ? {8'd0, cin} : 9'd0);
        o.r = s[7:0]; o.c = s[8]; o.v = (a[7] != b[7]) && (o.r[7] != a[7]);
      end else if (op == OP_AND) o.r = a & b;
      else if (op == OP_OR) o.r = a | b;
      else o.r = a;
    end else if (g == 2'b01) begin
      o.r = {a[6:0], cin}; o.c = a[7];
    end else if (g == 2'b10) begin
      o.r = ~a;
    end
    return o;
  endfunction

  a8_t alu_o;
  assign alu_o      = alu8(alu_operand_a, alu_operand_b, alu_group, alu_op, alu_carry_in);
  assign alu_result = alu_o.r;
  assign alu_flag_c = alu_o.c;
  assign alu_flag_v = alu_o.v;
  assign alu_flag_z = (alu_o.r == 8'd0);
  assign alu_flag_n = alu_o.r[7];

  // Wide reference: whole-operand arithmetic, no byte slicing.
  typedef struct packed { logic [W-1:0] r; logic z; logic n; logic c; logic v; } exp_t;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] g,
                                 input logic [5:0] op, input logic cin);
    logic [W:0] s;
    exp_t e;
    a8_t o;
    e = '0;
    s = '0;
    if (g == 2'b00) begin
      if (op == OP_ADD || op == OP_ADC) begin
        s = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? {{W{1'b0}}, cin} : '0);
        e.r = s[W-1:0]; e.c = s[W]; e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end else if (op == OP_SUB || op == OP_SBC) begin
        s = {1'b0, a} - {1'b0, b} - ((op == OP_SBC) ? {{W{1'b0}}, cin} : '0);
        e.r = s[W-1:0]; e.c = s[W]; e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end else if (op == OP_AND) e.r = a & b;
      else if (op == OP_OR) e.r = a | b;
      else e.r = a;
    end else begin
      o = alu8(a[7:0], b[7:0], g, op, cin);
      e.r = {a[W-1:8], o.r}; e.c = o.c; e.v = o.v;
    end
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   n_exec;
  logic [5:0] ex_op[8];
  logic       ex_cin[8];
  exp_t got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard and protocol checks on every cycle outputs are meaningful.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          chk("sb_resp", 32'({resp_result, resp_z, resp_n, resp_c, resp_v}), 32'(exp_q[0]));
          if (resp_ready) void'(exp_q.pop_front());
        end
        chk("sb_req_ready_in_done", 32'(req_ready), 32'd0);
      end
      if (req_ready && !resp_valid)
        chk("sb_alu_idle_zero", 32'({alu_operand_a, alu_operand_b, alu_group, alu_op, alu_carry_in}), 32'd0);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] g,
                        input logic [5:0] op, input logic cin, input int hold);
    int   k;
    bit   seen;
    exp_t snap;
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = a; req_b = b; req_group = g; req_op = op; req_carry_in = cin;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, g, op, cin));
    @(posedge clk); #1;
    // Scramble the request fields; the op in flight must not see them.
    req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom);
    req_group = 2'($urandom); req_op = 6'($urandom); req_carry_in = 1'($urandom);
    n_exec = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
      else begin
        if (n_exec < 8) begin ex_op[n_exec] = alu_op; ex_cin[n_exec] = alu_carry_in; end
        n_exec++;
      end
    end
    if (!seen) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    got  = {resp_result, resp_z, resp_n, resp_c, resp_v};
    snap = got;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_a = 16'h5555; req_b = 16'h0101; req_group = 2'b00; req_op = OP_ADD;
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_stable", 32'({resp_result, resp_z, resp_n, resp_c, resp_v}), 32'(snap));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", 32'({req_ready, resp_valid}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_handshake", 32'({req_ready, resp_valid}), 32'b10);
    chk("rst_resp", 32'({resp_result, resp_z, resp_n, resp_c, resp_v}), 32'd0);
    chk("rst_alu", 32'({alu_operand_a, alu_operand_b, alu_group, alu_op, alu_carry_in}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 0x00FF + 0x0001: byte-0 carry must ride into byte 1 as ADC.
    run_op(16'h00FF, 16'h0001, 2'b00, OP_ADD, 1'b0, 0);
    chk("add_ff_resp", 32'(got), 32'({16'h0100, 4'b0000}));
    chk("add_ff_nexec", 32'(n_exec), 32'd2);
    chk("add_ff_op0", 32'(ex_op[0]), 32'(OP_ADD));
    chk("add_ff_op1", 32'(ex_op[1]), 32'(OP_ADC));
    chk("add_ff_cin1", 32'(ex_cin[1]), 32'd1);

    run_op(16'hFFFF, 16'h0001, 2'b00, OP_ADD, 1'b0, 0);
    chk("add_wrap_resp", 32'(got), 32'({16'h0000, 4'b1010}));

    run_op(16'h7FFF, 16'h0001, 2'b00, OP_ADD, 1'b0, 0);
    chk("add_ovf_resp", 32'(got), 32'({16'h8000, 4'b0101}));

    run_op(16'h0100, 16'h0001, 2'b00, OP_SUB, 1'b0, 0);
    chk("sub_borrow_resp", 32'(got), 32'({16'h00FF, 4'b0000}));
    chk("sub_borrow_op1", 32'(ex_op[1]), 32'(OP_SBC));
    chk("sub_borrow_cin1", 32'(ex_cin[1]), 32'd1);

    // Backpressure: result held for 5 cycles while new requests are offered.
    run_op(16'h1234, 16'h1111, 2'b00, OP_ADC, 1'b1, 5);
    chk("adc_hold_resp", 32'(got), 32'({16'h2346, 4'b0000}));

    // Narrow shift: one byte executed, upper byte passes A through.
    run_op(16'h12F0, 16'h0000, 2'b01, 6'd0, 1'b0, 0);
    chk("narrow_nexec", 32'(n_exec), 32'd1);
    chk("narrow_hi", 32'(got.r[15:8]), 32'h12);
    chk("narrow_v", 32'(got.v), 32'd0);
    chk("narrow_resp", 32'(got), 32'({16'h12E0, 4'b0010}));

    run_op(16'h0000, 16'h0000, 2'b00, OP_SBC, 1'b1, 0);
    chk("sbc_neg_resp", 32'(got), 32'({16'hFFFF, 4'b0110}));

    run_op(16'h0F00, 16'h00F0, 2'b00, OP_OR, 1'b0, 0);
    chk("or_resp", 32'(got), 32'({16'h0FF0, 4'b0000}));

    // Reset while byte 1 is executing.
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = 16'h00FF; req_b = 16'h0001; req_group = 2'b00; req_op = OP_ADD; req_carry_in = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_byte0_op", 32'(alu_op), 32'(OP_ADD));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_handshake", 32'({req_ready, resp_valid}), 32'b10);
    chk("mid_rst_resp", 32'({resp_result, resp_z, resp_n, resp_c, resp_v}), 32'd0);
    chk("mid_rst_alu", 32'({alu_operand_a, alu_operand_b, alu_group, alu_op, alu_carry_in}), 32'd0);

    run_op(16'hF0F0, 16'h0FF0, 2'b00, OP_AND, 1'b0, 0);
    chk("post_rst_and_resp", 32'(got), 32'({16'h00F0, 4'b0000}));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
